// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-master SDRAM Wishbone port arbiter.
package sdram_arb_pkg;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT   = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CPU       = 3'd1,
    ST_DMA       = 3'd2,
    ST_DMA_BURST = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } master_e;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Inactivity watchdog: counts idle owned cycles and flags expiry at TIMEOUT-1.
module sdram_arb_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT - 1));
  // Activity in the limit cycle wins over expiry.
  assign o_expire   = i_enable & ~i_clear & w_at_limit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_enable || i_clear || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM Wishbone slave between the CPU and the
// DMA prefetch engine, with burst ownership, watchdog abort and a dead gap cycle.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [31:0] cpu_dat_o,
  input  logic        dma_cyc_i,
  input  logic        dma_stb_i,
  input  logic        dma_we_i,
  input  logic        dma_fun_sel_i,
  input  logic [31:0] dma_adr_i,
  output logic        dma_ack_o,
  output logic        dma_err_o,
  output logic        dma_burst_o,
  output logic [31:0] dma_dat_o,
  output logic        dram_cyc_o,
  output logic        dram_stb_o,
  output logic        dram_we_o,
  output logic [3:0]  dram_sel_o,
  output logic [31:0] dram_adr_o,
  output logic [31:0] dram_dat_o,
  output logic        dram_fun_sel_o,
  input  logic        dram_ack_i,
  input  logic        dram_burst_en_i,
  input  logic [31:0] dram_dat_i
);

  arb_state_e r_state;
  master_e    r_last_grant;
  logic       r_beat_seen;

  logic w_cpu_req;
  logic w_dma_req;
  logic w_own_cpu;
  logic w_own_dma;
  logic w_own_burst;
  logic w_wd_enable;
  logic w_activity;
  logic w_expire;

  assign w_cpu_req   = cpu_cyc_i & cpu_stb_i;
  assign w_dma_req   = dma_cyc_i & dma_stb_i;
  assign w_own_cpu   = (r_state == ST_CPU);
  assign w_own_dma   = (r_state == ST_DMA);
  assign w_own_burst = (r_state == ST_DMA_BURST);
  assign w_wd_enable = w_own_cpu | w_own_dma | w_own_burst;
  assign w_activity  = ((w_own_cpu | w_own_dma) & dram_ack_i) |
                       (w_own_burst & dram_burst_en_i);

  sdram_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_enable (w_wd_enable),
    .i_clear  (w_activity),
    .o_expire (w_expire)
  );

  // Ownership FSM; grant is registered so a request lands on dram_* one cycle later.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= MST_DMA;
      r_beat_seen  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat_seen <= 1'b0;
          if (w_cpu_req && (!w_dma_req || r_last_grant == MST_DMA)) begin
            r_state <= ST_CPU;
          end else if (w_dma_req) begin
            r_state <= ST_DMA;
          end
        end
        ST_CPU: begin
          if (dram_ack_i || !cpu_cyc_i || w_expire) begin
            r_state      <= ST_GAP;
            r_last_grant <= MST_CPU;
          end
        end
        ST_DMA: begin
          if (dram_ack_i) begin
            r_state     <= ST_DMA_BURST;
            r_beat_seen <= dram_burst_en_i;
          end else if (!dma_cyc_i || w_expire) begin
            r_state      <= ST_GAP;
            r_last_grant <= MST_DMA;
          end
        end
        ST_DMA_BURST: begin
          if (w_expire) begin
            r_state      <= ST_GAP;
            r_last_grant <= MST_DMA;
          end else if (dram_burst_en_i) begin
            r_beat_seen <= 1'b1;
          end else if (r_beat_seen) begin
            r_state      <= ST_GAP;
            r_last_grant <= MST_DMA;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    cpu_ack_o      = 1'b0;
    cpu_err_o      = 1'b0;
    cpu_dat_o      = '0;
    dma_ack_o      = 1'b0;
    dma_err_o      = 1'b0;
    dma_burst_o    = 1'b0;
    dma_dat_o      = '0;
    dram_cyc_o     = 1'b0;
    dram_stb_o     = 1'b0;
    dram_we_o      = 1'b0;
    dram_sel_o     = '0;
    dram_adr_o     = '0;
    dram_dat_o     = '0;
    dram_fun_sel_o = 1'b0;

    case (r_state)
      ST_CPU: begin
        dram_cyc_o = cpu_cyc_i & ~w_expire;
        dram_stb_o = cpu_stb_i & ~w_expire;
        dram_we_o  = cpu_we_i;
        dram_sel_o = cpu_sel_i;
        dram_adr_o = cpu_adr_i;
        dram_dat_o = cpu_dat_i;
        cpu_ack_o  = dram_ack_i;
        cpu_err_o  = w_expire;
        cpu_dat_o  = dram_dat_i;
      end
      ST_DMA: begin
        // The DMA engine only reads whole words, so all byte lanes are enabled.
        dram_cyc_o     = dma_cyc_i & ~w_expire;
        dram_stb_o     = dma_stb_i & ~w_expire;
        dram_we_o      = dma_we_i;
        dram_sel_o     = 4'hF;
        dram_adr_o     = dma_adr_i;
        dram_fun_sel_o = dma_fun_sel_i;
        dma_ack_o      = dram_ack_i;
        dma_err_o      = w_expire;
        dma_burst_o    = dram_ack_i & dram_burst_en_i;
        dma_dat_o      = dram_dat_i;
      end
      ST_DMA_BURST: begin
        dram_fun_sel_o = dma_fun_sel_i;
        dma_err_o      = w_expire;
        dma_burst_o    = dram_burst_en_i;
        dma_dat_o      = dram_dat_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (built with TIMEOUT=8).
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cyc, cpu_stb, cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_adr, cpu_wdat;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdat;
  logic        dma_cyc, dma_stb, dma_we, dma_fun_sel;
  logic [31:0] dma_adr;
  logic        dma_ack, dma_err, dma_burst;
  logic [31:0] dma_rdat;
  logic        dram_cyc, dram_stb, dram_we, dram_fun_sel;
  logic [3:0]  dram_sel;
  logic [31:0] dram_adr, dram_wdat;
  logic        dram_ack, dram_burst_en;
  logic [31:0] dram_rdat;

  int tests_run    = 0;
  int tests_failed = 0;

  wire [140:0] all_out = {cpu_ack, cpu_err, cpu_rdat, dma_ack, dma_err, dma_burst, dma_rdat,
                          dram_cyc, dram_stb, dram_we, dram_sel, dram_adr, dram_wdat, dram_fun_sel};

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .TIMEOUT (8),
    .CNT_W   (7)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .cpu_cyc_i       (cpu_cyc),
    .cpu_stb_i       (cpu_stb),
    .cpu_we_i        (cpu_we),
    .cpu_sel_i       (cpu_sel),
    .cpu_adr_i       (cpu_adr),
    .cpu_dat_i       (cpu_wdat),
    .cpu_ack_o       (cpu_ack),
    .cpu_err_o       (cpu_err),
    .cpu_dat_o       (cpu_rdat),
    .dma_cyc_i       (dma_cyc),
    .dma_stb_i       (dma_stb),
    .dma_we_i        (dma_we),
    .dma_fun_sel_i   (dma_fun_sel),
    .dma_adr_i       (dma_adr),
    .dma_ack_o       (dma_ack),
    .dma_err_o       (dma_err),
    .dma_burst_o     (dma_burst),
    .dma_dat_o       (dma_rdat),
    .dram_cyc_o      (dram_cyc),
    .dram_stb_o      (dram_stb),
    .dram_we_o       (dram_we),
    .dram_sel_o      (dram_sel),
    .dram_adr_o      (dram_adr),
    .dram_dat_o      (dram_wdat),
    .dram_fun_sel_o  (dram_fun_sel),
    .dram_ack_i      (dram_ack),
    .dram_burst_en_i (dram_burst_en),
    .dram_dat_i      (dram_rdat)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic drop_all();
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = 0; cpu_adr = 0; cpu_wdat = 0;
    dma_cyc = 0; dma_stb = 0; dma_we = 0; dma_fun_sel = 0; dma_adr = 0;
    dram_ack = 0; dram_burst_en = 0; dram_rdat = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_all();
    adv(); smp();
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    adv(); rst = 1'b0; smp();
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++; $display("FAIL post_reset_idle: got %h expected 0", all_out);
    end
  endtask

  task automatic test_cpu_read();
    adv();
    cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_sel = 4'hF; cpu_adr = 32'h3800_0010;
    smp();
    tests_run++;
    if (dram_cyc !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_grant_registered: dram_cyc got %b expected 0", dram_cyc);
    end
    adv(); smp();
    tests_run++;
    if ({dram_cyc, dram_stb, dram_we, dram_sel, dram_adr, dram_fun_sel, cpu_ack} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h3800_0010, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL cpu_forward: cyc=%b stb=%b sel=%h adr=%h fun=%b ack=%b expected 1 1 f 38000010 0 0",
               dram_cyc, dram_stb, dram_sel, dram_adr, dram_fun_sel, cpu_ack);
    end
    adv();
    adv(); dram_ack = 1; dram_rdat = 32'hDEAD_BEEF; smp();
    tests_run++;
    if ({cpu_ack, cpu_err, cpu_rdat} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL cpu_ack_data: ack=%b err=%b dat=%h expected 1 0 deadbeef", cpu_ack, cpu_err, cpu_rdat);
    end
    tests_run++;
    if ({dma_ack, dma_err, dma_burst, dma_rdat} !== '0) begin
      tests_failed++; $display("FAIL cpu_dma_quiet: got %b%b%b %h expected all 0", dma_ack, dma_err, dma_burst, dma_rdat);
    end
    adv(); dram_ack = 0; dram_rdat = 0; cpu_cyc = 0; cpu_stb = 0; smp();
    tests_run++;
    if ({cpu_ack, dram_cyc, dram_stb} !== 3'b000) begin
      tests_failed++; $display("FAIL cpu_gap: ack/cyc/stb got %b%b%b expected 000", cpu_ack, dram_cyc, dram_stb);
    end
    adv();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; adv(); rst = 1'b0;
    adv();
    cpu_cyc = 1; cpu_stb = 1; cpu_sel = 4'h3; cpu_adr = 32'h3800_0020;
    dma_cyc = 1; dma_stb = 1; dma_fun_sel = 0; dma_adr = 32'h3800_0100;
    smp();
    adv(); dram_ack = 1; dram_rdat = 32'h11; smp();
    tests_run++;
    if ({dram_adr, cpu_ack, dma_ack} !== {32'h3800_0020, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL rr_cpu_first: adr=%h cpu_ack=%b dma_ack=%b expected 38000020 1 0", dram_adr, cpu_ack, dma_ack);
    end
    adv(); dram_ack = 0; dram_rdat = 0; cpu_adr = 32'h3800_0030; smp();
    tests_run++;
    if (dram_cyc !== 1'b0) begin
      tests_failed++; $display("FAIL rr_gap_dead: dram_cyc got %b expected 0", dram_cyc);
    end
    adv(); smp();
    adv(); dram_ack = 1; dram_burst_en = 1; dram_rdat = 32'h22; smp();
    tests_run++;
    if ({dram_cyc, dram_adr, dram_sel} !== {1'b1, 32'h3800_0100, 4'hF}) begin
      tests_failed++; $display("FAIL rr_dma_second: cyc=%b adr=%h sel=%h expected 1 38000100 f", dram_cyc, dram_adr, dram_sel);
    end
    tests_run++;
    if ({cpu_ack, cpu_rdat, dma_ack, dma_burst, dma_rdat} !== {1'b0, 32'h0, 1'b1, 1'b1, 32'h22}) begin
      tests_failed++;
      $display("FAIL rr_dma_ack: cpu_ack=%b cpu_dat=%h dma_ack=%b burst=%b dat=%h expected 0 0 1 1 22",
               cpu_ack, cpu_rdat, dma_ack, dma_burst, dma_rdat);
    end
    adv(); dram_ack = 0; dram_burst_en = 0; dram_rdat = 0; smp();
    adv(); smp();
    adv(); smp();
    adv(); dram_ack = 1; dram_rdat = 32'h33; smp();
    tests_run++;
    if ({dram_adr, cpu_ack, dma_ack} !== {32'h3800_0030, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL rr_cpu_third: adr=%h cpu_ack=%b dma_ack=%b expected 38000030 1 0", dram_adr, cpu_ack, dma_ack);
    end
    adv(); drop_all();
    adv();
  endtask

  task automatic test_dma_burst();
    adv();
    dma_cyc = 1; dma_stb = 1; dma_fun_sel = 1; dma_adr = 32'h3800_0200;
    smp();
    adv(); dram_ack = 1; smp();
    tests_run++;
    if ({dram_cyc, dram_fun_sel, dma_ack, dma_burst} !== 4'b1110) begin
      tests_failed++; $display("FAIL dma_ack_funsel: cyc/fun/ack/burst got %b%b%b%b expected 1110", dram_cyc, dram_fun_sel, dma_ack, dma_burst);
    end
    for (int k = 1; k <= 4; k++) begin
      adv();
      dram_ack = 0; dma_cyc = 0; dma_stb = 0;
      cpu_cyc = 1; cpu_stb = 1; cpu_sel = 4'hF; cpu_adr = 32'h3800_0040;
      dram_burst_en = 1; dram_rdat = 32'(k);
      smp();
      tests_run++;
      if ({dram_cyc, dram_fun_sel, dma_burst, cpu_ack, dma_rdat} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'(k)}) begin
        tests_failed++;
        $display("FAIL burst_beat%0d: cyc=%b fun=%b burst=%b cpu_ack=%b dat=%h expected 0 1 1 0 %h",
                 k, dram_cyc, dram_fun_sel, dma_burst, cpu_ack, dma_rdat, 32'(k));
      end
    end
    adv(); dram_burst_en = 0; dram_rdat = 0; smp();
    tests_run++;
    if ({dma_burst, dram_cyc} !== 2'b00) begin
      tests_failed++; $display("FAIL burst_end: burst/cyc got %b%b expected 00", dma_burst, dram_cyc);
    end
    adv(); dma_fun_sel = 0; smp();
    tests_run++;
    if (dram_cyc !== 1'b0) begin
      tests_failed++; $display("FAIL burst_cpu_waits_gap: dram_cyc got %b expected 0", dram_cyc);
    end
    adv(); smp();
    adv(); dram_ack = 1; dram_rdat = 32'h44; smp();
    tests_run++;
    if ({dram_cyc, dram_fun_sel, dram_adr, cpu_ack} !== {1'b1, 1'b0, 32'h3800_0040, 1'b1}) begin
      tests_failed++; $display("FAIL burst_then_cpu: cyc=%b fun=%b adr=%h ack=%b expected 1 0 38000040 1", dram_cyc, dram_fun_sel, dram_adr, cpu_ack);
    end
    adv(); drop_all();
    adv();
  endtask

  task automatic test_timeout();
    adv();
    cpu_cyc = 1; cpu_stb = 1; cpu_sel = 4'hF; cpu_adr = 32'h3800_0050;
    smp();
    for (int i = 1; i <= 8; i++) begin
      adv(); smp();
      tests_run++;
      if ({cpu_err, cpu_ack} !== {(i == 8), 1'b0}) begin
        tests_failed++; $display("FAIL timeout_cycle%0d: err/ack got %b%b expected %b0", i, cpu_err, cpu_ack, (i == 8));
      end
      if (i < 8) begin
        tests_run++;
        if (dram_cyc !== 1'b1) begin
          tests_failed++; $display("FAIL timeout_owned%0d: dram_cyc got %b expected 1", i, dram_cyc);
        end
      end
    end
    adv(); smp();
    tests_run++;
    if ({dram_cyc, cpu_err, cpu_ack} !== 3'b000) begin
      tests_failed++; $display("FAIL timeout_dropped: cyc/err/ack got %b%b%b expected 000", dram_cyc, cpu_err, cpu_ack);
    end
    drop_all();
    adv();
  endtask

  task automatic test_stray_burst();
    for (int i = 0; i < 2; i++) begin
      adv(); dram_burst_en = 1; dram_rdat = 32'h55; smp();
      tests_run++;
      if ({dma_burst, dma_rdat, cpu_rdat, cpu_ack, dma_ack} !== '0) begin
        tests_failed++; $display("FAIL stray_burst%0d: burst=%b dma_dat=%h cpu_dat=%h expected 0 0 0", i, dma_burst, dma_rdat, cpu_rdat);
      end
    end
    adv(); drop_all();
  endtask

  task automatic test_reset_mid_burst();
    adv(); dma_cyc = 1; dma_stb = 1; dma_adr = 32'h3800_0300; smp();
    adv(); dram_ack = 1; smp();
    tests_run++;
    if (dma_ack !== 1'b1) begin
      tests_failed++; $display("FAIL rst_burst_ack: dma_ack got %b expected 1", dma_ack);
    end
    adv(); dram_ack = 0; dram_burst_en = 1; dram_rdat = 32'h66; smp();
    tests_run++;
    if (dma_burst !== 1'b1) begin
      tests_failed++; $display("FAIL rst_burst_beat: dma_burst got %b expected 1", dma_burst);
    end
    #1; rst = 1'b1; #1;
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++; $display("FAIL reset_mid_burst: got %h expected 0", all_out);
    end
    adv(); drop_all();
    adv(); rst = 1'b0; smp();
    adv(); cpu_cyc = 1; cpu_stb = 1; cpu_sel = 4'hF; cpu_adr = 32'h3800_0060; smp();
    adv(); dram_ack = 1; dram_rdat = 32'h77; smp();
    tests_run++;
    if ({dram_cyc, dram_adr, cpu_ack, cpu_rdat} !== {1'b1, 32'h3800_0060, 1'b1, 32'h77}) begin
      tests_failed++; $display("FAIL post_reset_cpu: cyc=%b adr=%h ack=%b dat=%h expected 1 38000060 1 77", dram_cyc, dram_adr, cpu_ack, cpu_rdat);
    end
    adv(); drop_all(); smp();
    tests_run++;
    if (cpu_ack !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_ack_pulse: cpu_ack got %b expected 0", cpu_ack);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_dma_burst();
    test_timeout();
    test_stray_burst();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
